// File: rtl/muskbus_responder.sv
// Muskbus responder: services line reads/writes from a DEPTH x BEATS x 64-bit line memory.
// Optional macro MUSKBUS_WAIT_STATES_EN inserts LATENCY wait cycles before the first read beat.
module muskbus_responder #(
  parameter int unsigned BEATS      = 8,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bid,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  input  logic        reqcyc,
  output logic        reqack,
  output logic [63:0] resp,
  output logic        respcyc,
  input  logic        respack
);

  localparam int unsigned BW   = $clog2(BEATS);
  localparam int unsigned LOFF = $clog2(BEATS * 8);
  localparam int unsigned AW   = DEPTH_LOG2 + BW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef MUSKBUS_WAIT_STATES_EN
  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;
  localparam int unsigned WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  logic [WW-1:0] wait_q, wait_d;
`else
  typedef enum logic [1:0] {IDLE, WDATA, RESP} state_t;
`endif

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [DEPTH_LOG2-1:0] line_q, line_d;
  logic [12:0]           tag_q, tag_d;
  logic [63:0]           resp_q, resp_d;
  logic                  respcyc_q, respcyc_d;

  logic [63:0]           mem [2**AW];
  logic                  mem_we;
  logic [AW-1:0]         mem_ra;
  logic [63:0]           mem_rd;
  logic [DEPTH_LOG2-1:0] req_line;

  assign req_line = req[LOFF+DEPTH_LOG2-1:LOFF];
  assign mem_rd   = mem[mem_ra];
  assign reqack   = reset_n && bid && reqcyc && (state_q == IDLE || state_q == WDATA);
  assign resp     = resp_q;
  assign respcyc  = respcyc_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    tag_d     = tag_q;
    resp_d    = resp_q;
    respcyc_d = respcyc_q;
    mem_we    = 1'b0;
    mem_ra    = {line_q, beat_q};
`ifdef MUSKBUS_WAIT_STATES_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (bid && reqcyc) begin
          line_d = req_line;
          tag_d  = reqtag;
          beat_d = '0;
          if (reqtag[12]) begin
            state_d = WDATA;
          end else begin
            // First read beat is fetched at accept so respcyc rises the very next cycle.
            mem_ra = {req_line, {BW{1'b0}}};
`ifdef MUSKBUS_WAIT_STATES_EN
            if (LATENCY == 0) begin
              resp_d    = mem_rd;
              respcyc_d = 1'b1;
              state_d   = RESP;
            end else begin
              wait_d  = '0;
              state_d = WAIT;
            end
`else
            resp_d    = mem_rd;
            respcyc_d = 1'b1;
            state_d   = RESP;
`endif
          end
        end
      end
      WDATA: begin
        if (!bid) begin
          state_d   = IDLE;
          respcyc_d = 1'b0;
          beat_d    = '0;
        end else if (reqcyc) begin
          mem_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            resp_d    = {51'b0, tag_q};
            respcyc_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
`ifdef MUSKBUS_WAIT_STATES_EN
      WAIT: begin
        if (!bid) begin
          state_d   = IDLE;
          respcyc_d = 1'b0;
          beat_d    = '0;
        end else if (wait_q == WW'(LATENCY - 1)) begin
          resp_d    = mem_rd;
          respcyc_d = 1'b1;
          state_d   = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`endif
      RESP: begin
        if (!bid) begin
          state_d   = IDLE;
          respcyc_d = 1'b0;
          beat_d    = '0;
        end else if (respack) begin
          if (tag_q[12] || beat_q == LAST_BEAT) begin
            state_d   = IDLE;
            respcyc_d = 1'b0;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + 1'b1;
            mem_ra = {line_q, beat_q + 1'b1};
            resp_d = mem_rd;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        respcyc_d = 1'b0;
        beat_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      line_q    <= '0;
      tag_q     <= '0;
      resp_q    <= '0;
      respcyc_q <= 1'b0;
`ifdef MUSKBUS_WAIT_STATES_EN
      wait_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      resp_q    <= resp_d;
      respcyc_q <= respcyc_d;
`ifdef MUSKBUS_WAIT_STATES_EN
      wait_q    <= wait_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[{line_q, beat_q}] <= req;
  end

endmodule

// File: tb/tb_muskbus_responder.sv
// Self-checking bench for muskbus_responder: transaction-level memory model plus per-cycle monitor.
module tb_muskbus_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        bid = 1'b0;
  logic [63:0] req = '0;
  logic [12:0] reqtag = '0;
  logic        reqcyc = 1'b0;
  logic        reqack;
  logic [63:0] resp;
  logic        respcyc;
  logic        respack = 1'b0;

  always #5 clk = ~clk;

  muskbus_responder #(.BEATS(8), .DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .bid(bid), .req(req), .reqtag(reqtag),
    .reqcyc(reqcyc), .reqack(reqack), .resp(resp), .respcyc(respcyc), .respack(respack)
  );

  int          compared = 0;
  int          mismatched = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_mem[int];
  bit          accepting = 1'b0;
  bit          done = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int line_of(input logic [63:0] a);
    return int'((a >> 6) & 64'd1023);
  endfunction

  // Responder accepts only while it is not busy responding; outputs meaningful every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      check("reqack", reqack, {63'b0, reset_n && bid && reqcyc && accepting});
      if (exp_q.size() > 0) begin
        check("respcyc", respcyc, 64'd1);
        check("resp", resp, exp_q[0]);
        if (respack) void'(exp_q.pop_front());
      end else begin
        check("respcyc_idle", respcyc, 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // stall_beat >= 0: ack every beat except hold 3 cycles at that beat; -2: always ack; -1: random ack
  task automatic drain(input int stall_beat);
    int n = 0;
    int st = 0;
    while (exp_q.size() > 0 && n < 300) begin
      if (8 - exp_q.size() == stall_beat && st < 3) begin
        respack = 1'b0;
        st++;
      end else if (stall_beat != -1) respack = 1'b1;
      else respack = ($urandom % 3 != 0);
      cyc();
      n++;
    end
    respack = 1'b0;
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    accepting = 1'b1;
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [11:0] tag,
                            input logic [63:0] d[8], input int abort_at);
    int ln = line_of(addr);
    bid = 1'b1; reqcyc = 1'b1; req = addr; reqtag = {1'b1, tag};
    cyc();
    for (int b = 0; b < 8; b++) begin
      if ($urandom % 4 == 0) begin
        reqcyc = 1'b0; req = {$urandom, $urandom};
        cyc();
      end
      if (b == abort_at) begin
        bid = 1'b0; reqcyc = 1'($urandom % 2); req = d[b];
        cyc();
        bid = 1'b1; reqcyc = 1'b0;
        return;
      end
      reqcyc = 1'b1; req = d[b];
      cyc();
      m_mem[ln*8+b] = d[b];
    end
    reqcyc = 1'b0;
    accepting = 1'b0;
    exp_q.push_back({51'b0, 1'b1, tag});
    drain(-1);
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [11:0] tag, input int stall_beat,
                           input int abort_at, input bit by_reset);
    int ln = line_of(addr);
    int n = 0;
    bid = 1'b1; reqcyc = 1'b1; req = addr; reqtag = {1'b0, tag};
    cyc();
    reqcyc = 1'b0; req = {$urandom, $urandom};
    accepting = 1'b0;
`ifdef MUSKBUS_WAIT_STATES_EN
    repeat (4) cyc();
`endif
    for (int b = 0; b < 8; b++) exp_q.push_back(m_mem[ln*8+b]);
    if (abort_at < 0) begin
      drain(stall_beat);
    end else begin
      while (8 - exp_q.size() < abort_at && n < 50) begin
        respack = 1'b1;
        cyc();
        n++;
      end
      if (by_reset) begin
        respack = 1'b0; reqcyc = 1'b1;
        #1 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_respcyc", respcyc, 64'd0);
        check("rst_resp", resp, 64'd0);
        check("rst_reqack", reqack, 64'd0);
        cyc();
        cyc();
        reset_n = 1'b1; reqcyc = 1'b0;
      end else begin
        bid = 1'b0; respack = 1'($urandom % 2);
        cyc();
        exp_q.delete();
        bid = 1'b1; respack = 1'b0;
      end
      accepting = 1'b1;
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d[8];
    logic [63:0] pin[8];
    logic [63:0] a;
    int          ln;
    #2 reset_n = 1'b0;
    #1;
    check("reset_resp", resp, 64'd0);
    check("reset_respcyc", respcyc, 64'd0);
    check("reset_reqack", reqack, 64'd0);
    cyc();
    cyc();
    reset_n = 1'b1;
    accepting = 1'b1;

    for (int i = 0; i < 8; i++) d[i] = 64'(i + 1);
    write_line(64'h40, 12'h005, d, -1);
    for (int i = 0; i < 8; i++) check("pin_write", m_mem[8+i], 64'(i + 1));
    read_line(64'h47, 12'h003, -2, -1, 1'b0);
    read_line(64'h40, 12'h004, 2, -1, 1'b0);

    for (int i = 0; i < 4; i++) d[i] = 64'(10 + i);
    write_line(64'h40, 12'h006, d, 4);
    pin[0] = 64'hA; pin[1] = 64'hB; pin[2] = 64'hC; pin[3] = 64'hD;
    pin[4] = 64'h5; pin[5] = 64'h6; pin[6] = 64'h7; pin[7] = 64'h8;
    for (int i = 0; i < 8; i++) check("pin_abort", m_mem[8+i], pin[i]);
    read_line(64'h40, 12'h007, -2, -1, 1'b0);

    read_line(64'h40, 12'h008, -2, 5, 1'b1);
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    write_line(64'h40, 12'h009, d, -1);
    read_line(64'h40, 12'h00A, -2, -1, 1'b0);

    for (int l = 0; l < 8; l++) begin
      for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
      write_line(64'(l) << 6, 12'(l), d, -1);
    end

    for (int t = 0; t < 40; t++) begin
      ln = int'($urandom % 8);
      a  = (64'(ln) << 6) | 64'($urandom % 64) | (64'($urandom % 4) << 16);
      for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
      case ($urandom % 5)
        0:       write_line(a, 12'($urandom), d, -1);
        1:       write_line(a, 12'($urandom), d, int'($urandom % 8));
        2:       read_line(a, 12'($urandom), -1, int'($urandom % 8), 1'b0);
        3:       read_line(a, 12'($urandom), int'($urandom % 8), -1, 1'b0);
        default: read_line(a, 12'($urandom), -1, -1, 1'b0);
      endcase
      if ($urandom % 3 == 0) begin
        bid = 1'($urandom % 2); reqcyc = 1'b0;
        cyc();
        bid = 1'b1;
      end
    end

    cyc();
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
